// File: rtl/count_display_driver.sv
// Latches a 4-bit count, converts it to decimal or hex digits and scans two
// active-low common-anode seven-segment digits at a programmable refresh rate.
module count_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       load,
  input  logic       hex_mode,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_DARK = 7'b1111111;

  logic [3:0]    shadow_r;
  logic          tens_r;
  logic [3:0]    ones_r;
  logic          mode_r;
  logic [CW-1:0] cnt_r;
  logic          sel_r;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Sample stage: capture the upstream count on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r <= 4'd0;
    end else if (load) begin
      shadow_r <= value;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Convert stage; mode is carried along so blanking and digit change together.
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_r <= 1'b0;
      ones_r <= 4'd0;
      mode_r <= 1'b0;
    end else if (hex_mode) begin
      tens_r <= 1'b0;
      ones_r <= shadow_r;
      mode_r <= 1'b1;
    end else if (shadow_r >= 4'd10) begin
      tens_r <= 1'b1;
      ones_r <= shadow_r - 4'd10;
      mode_r <= 1'b0;
    end else begin
      tens_r <= 1'b0;
      ones_r <= shadow_r;
      mode_r <= 1'b0;
    end
  end

  // Refresh timer: each digit slot lasts exactly REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      sel_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      sel_r <= ~sel_r;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      sel_r <= sel_r;
    end
  end

  // Output stage: tens slot is still consumed when blanked, keeping the scan period fixed.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 2'b11;
      seg <= SEG_DARK;
    end else if (!sel_r) begin
      an  <= 2'b10;
      seg <= glyph(ones_r);
    end else if (mode_r || !tens_r) begin
      an  <= 2'b11;
      seg <= SEG_DARK;
    end else begin
      an  <= 2'b01;
      seg <= glyph(4'd1);
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized and directed checks of count_display_driver against a
// cycle-level numeric model of the displayed value and scan slot.
module tb_count_display_driver;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] value = 4'd0;
  logic       load = 1'b0;
  logic       hex_mode = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state: edges since reset, latched count, value/mode feeding the display.
  int         n_edges = 0;
  int         shadow_m = 0;
  int         disp_val = 0;
  int         disp_hex = 0;
  logic [6:0] exp_seg = 7'b1111111;
  logic [1:0] exp_an = 2'b11;

  count_display_driver #(.REFRESH_DIV(R)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .hex_mode(hex_mode), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_edge();
    int sel;
    if (reset) begin
      exp_seg = 7'b1111111; exp_an = 2'b11;
      shadow_m = 0; disp_val = 0; disp_hex = 0; n_edges = 0;
    end else begin
      n_edges++;
      sel = ((n_edges - 1) / R) % 2;
      if (sel == 0) begin
        exp_an  = 2'b10;
        exp_seg = glyph_tab[disp_hex != 0 ? disp_val : disp_val % 10];
      end else if (disp_hex != 0 || disp_val < 10) begin
        exp_an  = 2'b11;
        exp_seg = 7'b1111111;
      end else begin
        exp_an  = 2'b01;
        exp_seg = glyph_tab[disp_val / 10];
      end
      disp_val = shadow_m;
      disp_hex = int'(hex_mode);
      if (load) shadow_m = int'(value);
    end
  endtask

  task automatic cycle(input logic r, input logic l, input logic [3:0] v, input logic h);
    @(negedge clk);
    reset = r; load = l; value = v; hex_mode = h;
    @(posedge clk);
    model_edge();
    #1;
    check("seg", {1'b0, seg}, {1'b0, exp_seg});
    check("an", {6'd0, an}, {6'd0, exp_an});
    check("an_one_low", {7'd0, an == 2'b00}, 8'd0);
  endtask

  initial begin
    // 1: reset then free scan showing 0
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    // 2: 13 decimal
    cycle(1'b0, 1'b1, 4'd13, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    // 3: 7 decimal, tens blanked
    cycle(1'b0, 1'b1, 4'd7, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    // 4: 11 with hex toggle
    cycle(1'b0, 1'b1, 4'd11, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    // 5: continuous load stepping 15 down through 0 and wrapping
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 4'(15 - i), 1'b0);
    // 6: reset during the tens slot while showing 12
    cycle(1'b0, 1'b1, 4'd12, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (n_edges > R && ((n_edges / R) % 2) == 1 && i > 3) break;
      cycle(1'b0, 1'b0, 4'd0, 1'b0);
    end
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'd0, 1'b0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            (i % 64) >= 48 ? 1'b1 : 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 4-bit free-running counter value.
- Latches the count on a strobe and converts it to two decimal digits, or to one hex digit.
- Time-multiplexes two active-low common-anode seven-segment digits at a programmable refresh rate.
- Sits between the counter and the board display pins; all outputs are registered.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit stays lit per scan slot; legal range >= 2; refresh counter width = clog2(REFRESH_DIV).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value  input  4  count from upstream counter, 0..15
load  input  1  sample strobe; value is captured on a clk edge where load=1
hex_mode  input  1  1 = single hex digit on digit0; 0 = two-digit decimal
seg  output  7  segments, active low; seg[6]=a, seg[5]=b, ..., seg[0]=g
an  output  2  digit anodes, active low; an[0]=ones/hex digit, an[1]=tens digit

Behaviour:
- Reset state (reset sampled high at an edge):
  - shadow=0, tens=0, ones=0.
  - refresh counter=0, digit select sel=0.
  - seg=7'b1111111, an=2'b11 (display dark).
  - reset has priority over load and over refresh activity; asserting it mid-scan darkens the display on the next edge.
- Sample stage: if load=1 at edge k, shadow<=value at edge k. load=0 holds shadow. Continuous load=1 tracks value every cycle.
- Convert stage (registered, edge after shadow changes):
  - hex_mode=0: tens<=(shadow>=10), ones<=shadow-10*tens; result 4 bits, 0..9.
  - hex_mode=1: ones<=shadow, tens<=0.
  - hex_mode is sampled by this stage each cycle, so a mode change is visible at seg/an after 2 edges.
- Refresh:
  - Counter increments every cycle, 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and sel toggles.
  - Digit period is exactly REFRESH_DIV cycles; a full scan is 2*REFRESH_DIV cycles.
- Output stage (registered from sel, tens, ones, hex_mode):
  - sel=0: an<=2'b10, seg<=glyph(ones).
  - sel=1 and (hex_mode=1 or tens=0): an<=2'b11, seg<=7'b1111111. This is leading-zero and hex blanking; the slot is still consumed.
  - sel=1 otherwise: an<=2'b01, seg<=glyph(1).
- Latency:
  - load edge k → shadow at k → tens/ones at k+1 → seg/an at k+2.
  - seg/an follow a sel toggle one edge later.
- First edge after reset releases: an=2'b10, seg=glyph(0)=7'b0000001.
- Glyph table, active low, abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Invariant: never more than one an bit low in any cycle.
- Glitch-free outputs: seg and an change only on clk edges.

Test Plan:
(Bench uses REFRESH_DIV=4.)
1. Hold reset 3 cycles, then release → seg=1111111 and an=11 during reset; first edge after release gives an=10, seg=0000001; sel toggles every 4 cycles; an[1] stays 1 (tens blanked).
2. value=13, load pulse 1 cycle, hex_mode=0 → 2 edges later the ones slot shows seg=0000110 with an=10; the tens slot shows seg=1001111 with an=01; the pattern alternates every 4 cycles.
3. value=7 loaded, hex_mode=0 → ones slot shows 0001111; tens slot has an=11 and seg=1111111; period unchanged.
4. value=11 loaded, then toggle hex_mode 0→1 → within 2 edges digit0 shows b=1100000; digit1 is blanked; back to 0 restores "11".
5. load=1 continuously while value steps 15→0 (wrap) → seg sequence on the ones slot follows with 2-cycle lag; 15 in decimal shows "15"; 0 shows "0" with tens blank. Confirm an is never 00 throughout.
6. Assert reset mid tens slot while displaying 12 → next edge seg=1111111, an=11; after release the display shows 0 and refresh restarts from count 0 with sel=0.
